// File: rtl/multicycle_adder.sv
// multicycle_adder: adds or subtracts WIDTH-bit operands CHUNK bits per cycle
// behind a valid/ready handshake, reporting carry, signed overflow and zero.
module multicycle_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ofl,
   output logic             Zero
);
   localparam int N = WIDTH / CHUNK;
   localparam int IW = N > 1 ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] a_r, b_r, s_n;
   logic [IW-1:0] idx;
   logic carry, last;
   logic [CHUNK:0] csum;
   assign in_ready = state == IDLE;
   assign out_valid = state == DONE;
   assign last = idx == LAST;
   always_comb begin
      csum = {1'b0, a_r[idx*CHUNK +: CHUNK]} + {1'b0, b_r[idx*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry};
      s_n = S;
      s_n[idx*CHUNK +: CHUNK] = csum[CHUNK-1:0];
   end
   always_comb begin
      state_n = state;
      if (state == IDLE && in_valid) state_n = CALC;
      else if (state == CALC && last) state_n = DONE;
      else if (state == DONE && out_ready) state_n = IDLE;
   end
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_n;
   // Subtraction is folded into the latch: B is inverted and the carry seeds the +1.
   always_ff @(posedge clk)
      if (rst) begin
         S <= '0;
         Cout <= 1'b0;
         Ofl <= 1'b0;
         Zero <= 1'b0;
         idx <= '0;
         carry <= 1'b0;
         a_r <= '0;
         b_r <= '0;
      end else if (state == IDLE && in_valid) begin
         a_r <= A;
         b_r <= B ^ {WIDTH{sub}};
         carry <= sub | Cin;
         idx <= '0;
      end else if (state == CALC) begin
         S <= s_n;
         carry <= csum[CHUNK];
         idx <= idx + 1'b1;
         if (last) begin
            Cout <= csum[CHUNK];
            Ofl <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s_n[WIDTH-1] != a_r[WIDTH-1]);
            Zero <= ~|s_n;
         end
      end
endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: random and directed checks of multicycle_adder against
// an integer-arithmetic reference model, including hold, reset-abort and wide configs.
module tb_multicycle_adder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0, out_ready = 1'b0, Cin = 1'b0, sub = 1'b0;
   logic [15:0] A = '0, B = '0;
   logic in_ready, out_valid, Cout, Ofl, Zero;
   logic [15:0] S;
   logic v32 = 1'b0, r32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic ir8, ov8, c8, o8, z8, ir32, ov32, c32, o32, z32;
   logic [31:0] s8, s32;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
      .Cin(Cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .S(S),
      .Cout(Cout), .Ofl(Ofl), .Zero(Zero));
   multicycle_adder #(.WIDTH(32), .CHUNK(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir8), .A(a32), .B(b32),
      .Cin(1'b0), .sub(1'b0), .out_valid(ov8), .out_ready(r32), .S(s8),
      .Cout(c8), .Ofl(o8), .Zero(z8));
   multicycle_adder #(.WIDTH(32), .CHUNK(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32), .A(a32), .B(b32),
      .Cin(1'b0), .sub(1'b0), .out_valid(ov32), .out_ready(r32), .S(s32),
      .Cout(c32), .Ofl(o32), .Zero(z32));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic on the operands as given.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sb, input bit hold);
      logic [15:0] es;
      logic ec, eo, ez;
      int ai, bi, sa, ua, lat;
      ai = $signed(a);
      bi = $signed(b);
      sa = sb ? ai - bi : ai + bi + int'(cin);
      ua = sb ? int'(a) - int'(b) : int'(a) + int'(b) + int'(cin);
      es = 16'(ua);
      ec = sb ? (a >= b) : (ua > 65535);
      eo = sa > 32767 || sa < -32768;
      ez = es == 16'h0;
      check("ready_before", in_ready, 1);
      A = a; B = b; Cin = cin; sub = sb; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); sub = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("latency", 64'(lat), 4);
      check("S", S, 64'(es));
      check("Cout", Cout, 64'(ec));
      check("Ofl", Ofl, 64'(eo));
      check("Zero", Zero, 64'(ez));
      check("busy_in_done", in_ready, 0);
      if (hold) begin
         for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            A = 16'($urandom); B = 16'($urandom); Cin = ~Cin; sub = ~sub;
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_S", S, 64'(es));
            check("hold_flags", {Cout, Ofl, Zero}, 64'({ec, eo, ez}));
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid = 1'b0;
      check("retire_valid", out_valid, 0);
      check("retire_ready", in_ready, 1);
   endtask

   initial begin
      int lat8, lat32;
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lat8, lat32;
      tick();
      tick();
      rst = 1'b0;
      check("rst_ready", in_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_S", S, 0);
      check("rst_flags", {Cout, Ofl, Zero}, 0);
      tick();
      check("idle_hold", {in_ready, out_valid}, 2'b10);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
      run_op(16'h1234, 16'h1111, 1'b1, 1'b0, 0);
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
      run_op(16'h0003, 16'h0005, 1'b1, 1'b1, 0);
      run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1);
      run_op(16'h0000, 16'h8000, 1'b0, 1'b1, 0);
      // Abort mid-calculation: reset two cycles after the accept.
      A = 16'h1234; B = 16'h1111; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_valid", out_valid, 0);
      check("abort_ready", in_ready, 1);
      check("abort_S", S, 0);
      check("abort_flags", {Cout, Ofl, Zero}, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort_no_pulse", out_valid, 0);
      end
      run_op(16'h0002, 16'h0003, 1'b0, 1'b0, 0);
      for (int i = 0; i < 40; i++)
         run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), i % 10 == 0);
      a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; v32 = 1'b1;
      tick();
      v32 = 1'b0;
      lat8 = 0;
      lat32 = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (ov8 && lat8 == 0) lat8 = i;
         if (ov32 && lat32 == 0) lat32 = i;
      end
      check("w32c8_latency", 64'(lat8), 4);
      check("w32c8_S", s8, 0);
      check("w32c8_Cout", c8, 1);
      check("w32c8_Zero", z8, 1);
      check("w32c32_latency", 64'(lat32), 1);
      check("w32c32_S", s32, 0);
      check("w32c32_Cout", c32, 1);
      check("w32c32_Ofl", {o8, o32}, 0);
      r32 = 1'b1;
      tick();
      r32 = 1'b0;
      check("w32_retire", {ir8, ov8, ir32, ov32}, 4'b1010);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
